// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake
// into a small prefetch queue and presents the head {pc, inst} to IF/ID.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_drain_addr;
    logic [31:0]   w_drain_addr_nxt;
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [31:0]   r_q_inst [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_space;

    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && !stall_i && !flush_i;
    assign w_push  = (r_state == S_REQ) && imem_ack_i && !flush_i;

    // Space is judged on the occupancy after this cycle's push/pop, so a pop
    // frees room for a request that appears on the bus in the next cycle.
    assign w_count_nxt = flush_i ? '0
                       : (r_count + CW'(w_push) - CW'(w_pop));
    assign w_space     = (w_count_nxt < CW'(QDEPTH));

    always_comb begin
        w_state_nxt      = r_state;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_drain_addr_nxt = r_drain_addr;
        case (r_state)
            S_IDLE: begin
                if (!flush_i && w_space) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    if (imem_ack_i) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_addr_nxt = r_fetch_pc;
                    end
                end else if (imem_ack_i) begin
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = w_space ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                // The stale request must complete before a new one may issue.
                if (imem_ack_i) begin
                    w_state_nxt = (!flush_i && w_space) ? S_REQ : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (flush_i) begin
            w_fetch_pc_nxt = branch_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= 32'h0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_count      <= w_count_nxt;
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_fetch_pc;
            r_q_inst[r_wr_ptr] <= imem_data_i;
        end
    end

    assign imem_req_o  = !rst_i && (r_state != S_IDLE);
    assign imem_addr_o = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;
    assign valid_o     = !rst_i && !w_empty;
    assign pc_o        = valid_o ? r_q_pc[r_rd_ptr]   : 32'h0;
    assign inst_o      = valid_o ? r_q_inst[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random traffic, all
// cycles compared against a queue-based reference model.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] XK       = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;

    int lat;
    int wcnt;
    bit spur;
    int n_pass  = 0;
    int n_total = 0;
    bit found;

    logic [63:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_stale;
    bit          m_acked;

    inst_fetch_unit #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stall_i        (stall),
        .flush_i        (flush),
        .branch_target_i(tgt),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_ack_i     (ack),
        .imem_data_i    (data),
        .pc_o           (pc),
        .inst_o         (inst),
        .valid_o        (valid)
    );

    always #5 clk = ~clk;

    // Memory: acks after `lat` wait cycles of a held request; stray acks when idle.
    assign ack  = req ? (wcnt >= lat) : spur;
    assign data = addr ^ XK;

    always @(posedge clk) begin
        if (rst)       wcnt <= 0;
        else if (ack)  wcnt <= 0;
        else if (req)  wcnt <= wcnt + 1;
    end

    // Reference model: queue of fetched {pc,inst}, one outstanding fetch flag,
    // and a flag marking that outstanding fetch as stale after a redirect.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_fpc   = RESET_PC;
            m_busy  = 1'b0;
            m_stale = 1'b0;
        end else begin
            m_acked = m_busy && ack;
            if (flush) begin
                mq.delete();
                m_fpc = tgt;
                if (m_busy && !m_acked) begin
                    m_stale = 1'b1;
                end else begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end
            end else begin
                if (mq.size() > 0 && !stall) mq.delete(0);
                if (m_acked) begin
                    if (!m_stale) begin
                        mq.push_back({m_fpc, m_addr ^ XK});
                        m_fpc = m_fpc + 32'd4;
                    end
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end
                if (!m_busy && mq.size() < QDEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_fpc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        logic        e_req;
        logic        e_valid;
        @(negedge clk);
        e_req   = !rst && m_busy;
        e_valid = !rst && (mq.size() > 0);
        chk("m_req", 32'(req), 32'(e_req));
        if (e_req) chk("m_addr", addr, m_addr);
        chk("m_valid", 32'(valid), 32'(e_valid));
        chk("m_pc",   pc,   e_valid ? mq[0][63:32] : 32'h0);
        chk("m_inst", inst, e_valid ? mq[0][31:0]  : 32'h0);
    endtask

    initial begin
        logic [31:0] rnd;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; tgt = 32'h0; lat = 0; spur = 1'b0;

        // Reset, then zero-wait streaming
        cyc(); cyc();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        rst = 1'b0;
        cyc(); chk("zw_req0", 32'(req), 32'd1); chk("zw_addr0", addr, 32'h0);
        cyc(); chk("zw_valid0", 32'(valid), 32'd1); chk("zw_pc0", pc, 32'h0);
        chk("zw_inst0", inst, XK);
        cyc(); chk("zw_pc4", pc, 32'h4); chk("zw_inst4", inst, 32'h4 ^ XK);
        cyc(); chk("zw_pc8", pc, 32'h8);
        repeat (4) cyc();

        // Three-cycle memory latency
        rst = 1'b1; lat = 2; cyc(); rst = 1'b0;
        cyc(); chk("l3_addr_a", addr, 32'h0); chk("l3_ack_a", 32'(ack), 32'd0);
        cyc(); chk("l3_addr_b", addr, 32'h0); chk("l3_valid_b", 32'(valid), 32'd0);
        cyc(); chk("l3_addr_c", addr, 32'h0); chk("l3_ack_c", 32'(ack), 32'd1);
        cyc(); chk("l3_valid_d", 32'(valid), 32'd1); chk("l3_pc_d", pc, 32'h0);
        chk("l3_addr_d", addr, 32'h4);
        cyc(); chk("l3_valid_e", 32'(valid), 32'd0);

        // Stall held with zero-wait memory
        rst = 1'b1; lat = 0; stall = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk("st_pc_hold", pc, 32'h0);
        end
        chk("st_req_drop", 32'(req), 32'd0);
        chk("st_valid", 32'(valid), 32'd1);
        stall = 1'b0;
        cyc(); chk("st_rel_pc4", pc, 32'h4); chk("st_rel_v4", 32'(valid), 32'd1);
        cyc(); chk("st_rel_pc8", pc, 32'h8); chk("st_rel_v8", 32'(valid), 32'd1);
        cyc(); chk("st_rel_pc12", pc, 32'hC);

        // Redirect while the fetch of 8 is in flight
        rst = 1'b1; lat = 2; cyc(); rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (req && addr == 32'h8 && !ack) begin found = 1'b1; break; end
        end
        chk("fl_reach8", 32'(found), 32'd1);
        flush = 1'b1; tgt = 32'h100;
        cyc(); flush = 1'b0;
        chk("fl_drain_req", 32'(req), 32'd1);
        chk("fl_drain_addr", addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (valid) begin found = 1'b1; chk("fl_first_pc", pc, 32'h100); break; end
        end
        chk("fl_got_valid", 32'(found), 32'd1);

        // Redirect coinciding with an ack while stalled
        rst = 1'b1; lat = 2; stall = 1'b1; cyc(); rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (req && addr == 32'h4 && ack) begin found = 1'b1; break; end
        end
        chk("fa_reach4", 32'(found), 32'd1);
        flush = 1'b1; tgt = 32'h200;
        cyc(); flush = 1'b0;
        chk("fa_valid", 32'(valid), 32'd0);
        chk("fa_req", 32'(req), 32'd0);
        cyc(); chk("fa_req_t", 32'(req), 32'd1); chk("fa_addr_t", addr, 32'h200);
        stall = 1'b0;

        // Reset pulse during an outstanding request
        rst = 1'b1; lat = 2; cyc(); rst = 1'b0;
        cyc(); chk("rm_req_before", 32'(req), 32'd1);
        rst = 1'b1;
        cyc(); chk("rm_req", 32'(req), 32'd0); chk("rm_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        cyc(); chk("rm_restart", addr, RESET_PC); chk("rm_req_again", 32'(req), 32'd1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 99) < 8);
            rnd   = $urandom();
            tgt   = rnd & 32'hFFFF_FFFC;
            lat   = $urandom_range(0, 3);
            spur  = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
